// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bundle: instruction-memory read port plus decode-side valid/ready.
// master = fetch unit, slave = memory/decode side.
interface fetch_queue_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Sequential-PC fetch into a DEPTH-entry queue; FETCH_STATS_EN adds pop/redirect counters.
// Latency: request in k, data pushed at end of k+1, inst_valid in k+2; redirect target shown 3 cycles later.
// Backpressure: requests stop while queued + in-flight entries fill DEPTH; one credit per pop.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect,
    input  logic [XLEN-1:0]         redirect_pc,
    fetch_queue_unit_if.master      bus,
`ifdef FETCH_STATS_EN
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             fetched_cnt,
    output logic [31:0]             redirect_cnt
`else
    output logic [$clog2(DEPTH):0]  count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] inst_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];

    logic [CW:0]     used;
    logic            req;
    logic            push;
    logic            pop;
    logic            unused_pc_lsbs;

    // Credits cover both stored entries and the read still in flight.
    assign used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign req  = rst && !redirect && (used < (CW+1)'(DEPTH));
    assign push = inflight_q && !redirect;
    assign pop  = bus.inst_valid && bus.inst_ready && !redirect;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = bus.inst_valid ? inst_q[rd_ptr_q] : '0;
    assign bus.inst_pc    = bus.inst_valid ? pc_q[rd_ptr_q]   : '0;
    assign count          = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        wr_ptr_d      = wr_ptr_q + AW'(push);
        count_d       = count_q + CW'(push) - CW'(pop);
        if (req) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_pc_d = fetch_pc_q;
        end
        if (redirect) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr_q] <= bus.imem_rdata;
            pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] redirect_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q  <= '0;
            redirect_q <= '0;
        end else begin
            if (pop)      fetched_q  <= fetched_q + 32'd1;
            if (redirect) redirect_q <= redirect_q + 32'd1;
        end
    end

    assign fetched_cnt  = fetched_q;
    assign redirect_cnt = redirect_q;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: imem word at address a holds 0x1000 + a/4.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
`ifdef FETCH_STATS_EN
    logic [31:0] fetched_cnt;
    logic [31:0] redirect_cnt;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int nreq;

    fetch_queue_unit_if #(.XLEN(32)) bus ();

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .bus          (bus),
`ifdef FETCH_STATS_EN
        .count        (count),
        .fetched_cnt  (fetched_cnt),
        .redirect_cnt (redirect_cnt)
`else
        .count        (count)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory.
    always @(posedge clk)
        if (bus.imem_req) bus.imem_rdata <= 32'h1000 + (bus.imem_addr >> 2);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 2 time units into cycle 0 after reset release.
    task automatic restart;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; bus.inst_ready = 1'b1;
        bus.imem_rdata = '0;

        // Reset values and first stream
        tick(); tick();
        chk("rst_req",   bus.imem_req,   0);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_inst",  bus.inst,       0);
        chk("rst_pc",    bus.inst_pc,    0);
        chk("rst_count", count,          0);
        rst = 1'b1; #1;
        chk("c0_req",  bus.imem_req,  1);
        chk("c0_addr", bus.imem_addr, 32'h0);
        tick();
        chk("c1_valid", bus.inst_valid, 0);
        chk("c1_addr",  bus.imem_addr,  32'h4);
        tick();
        chk("c2_valid", bus.inst_valid, 1);
        chk("c2_inst",  bus.inst,       32'h1000);
        chk("c2_pc",    bus.inst_pc,    32'h0);
        tick();
        chk("c3_inst",  bus.inst,       32'h1001);
        chk("c3_pc",    bus.inst_pc,    32'h4);
        tick();
        chk("c4_inst",  bus.inst,       32'h1002);
        chk("c4_pc",    bus.inst_pc,    32'h8);
        chk("c4_count", count,          1);

        // Backpressure: credits run out at DEPTH
        bus.inst_ready = 1'b0;
        restart();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req) nreq++;
            tick();
        end
        chk("bp_nreq",  nreq,         4);
        chk("bp_count", count,        4);
        chk("bp_req",   bus.imem_req, 0);
        chk("bp_head",  bus.inst_pc,  32'h0);
        bus.inst_ready = 1'b1; #1;
        chk("bp_pop_valid", bus.inst_valid, 1);
        tick();
        bus.inst_ready = 1'b0; #1;
        chk("bp_resume_req",  bus.imem_req,  1);
        chk("bp_resume_addr", bus.imem_addr, 32'h10);
        chk("bp_after_pop",   count,         3);
        chk("bp_after_head",  bus.inst_pc,   32'h4);
        tick();
        chk("bp_full_req",    bus.imem_req,  0);
        chk("bp_full_count3", count,         3);
        tick();
        chk("bp_refill",      count,         4);

        // Redirect in a steady stream (pop and response in the same cycle)
        bus.inst_ready = 1'b1;
        restart();
        for (int i = 0; i < 5; i++) tick();
        chk("rd_old_head", bus.inst_pc, 32'hC);
        redirect = 1'b1; redirect_pc = 32'h43; #1;
        chk("rd_req_blocked", bus.imem_req, 0);
        tick();
        redirect = 1'b0; #1;
        chk("rd_n1_valid", bus.inst_valid, 0);
        chk("rd_n1_count", count,          0);
        chk("rd_n1_req",   bus.imem_req,   1);
        chk("rd_n1_addr",  bus.imem_addr,  32'h40);
        tick();
        chk("rd_n2_valid", bus.inst_valid, 0);
        tick();
        chk("rd_n3_valid", bus.inst_valid, 1);
        chk("rd_n3_pc",    bus.inst_pc,    32'h40);
        chk("rd_n3_inst",  bus.inst,       32'h1010);
        tick();
        chk("rd_n4_pc",    bus.inst_pc,    32'h44);

        // Redirect with 3 queued, a pop and a response arriving; target wraps
        bus.inst_ready = 1'b0;
        restart();
        for (int i = 0; i < 4; i++) tick();
        chk("rf_count3", count, 3);
        bus.inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk("rf_pop_valid", bus.inst_valid, 1);
        tick();
        redirect = 1'b0; #1;
        chk("rf_count", count,          0);
        chk("rf_valid", bus.inst_valid, 0);
        chk("rf_addr",  bus.imem_addr,  32'hFFFF_FFFC);
        tick();
        chk("rf_drop_count", count,         0);
        chk("rf_wrap_addr",  bus.imem_addr, 32'h0);
        tick();
        chk("rf_wrap_pc0", bus.inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("rf_wrap_pc1", bus.inst_pc, 32'h0);

        // Asynchronous reset pulse while count=3
        bus.inst_ready = 1'b0;
        restart();
        for (int i = 0; i < 4; i++) tick();
        chk("ar_pre_count", count, 3);
        rst = 1'b0; #1;
        chk("ar_valid", bus.inst_valid, 0);
        chk("ar_inst",  bus.inst,       0);
        chk("ar_pc",    bus.inst_pc,    0);
        chk("ar_count", count,          0);
        chk("ar_req",   bus.imem_req,   0);
        tick();
        rst = 1'b1; #1;
        chk("ar_restart_req",  bus.imem_req,  1);
        chk("ar_restart_addr", bus.imem_addr, 32'h0);
        tick();
        chk("ar_no_stale", count, 0);
        bus.inst_ready = 1'b1;
        tick();
        chk("ar_first_pc",   bus.inst_pc, 32'h0);
        chk("ar_first_inst", bus.inst,    32'h1000);

`ifdef FETCH_STATS_EN
        // 10 pops then 2 redirects
        bus.inst_ready = 1'b1;
        restart();
        tick(); tick();
        for (int i = 0; i < 10; i++) tick();
        bus.inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        tick();
        redirect = 1'b1;
        tick();
        redirect = 1'b0; #1;
        chk("st_fetched",  fetched_cnt,  10);
        chk("st_redirect", redirect_cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end that generates sequential PCs, drives a synchronous instruction memory with one-cycle read latency, and buffers returned instructions in a DEPTH-entry FIFO feeding decode through a valid/ready handshake. It supersedes the single-instruction fetch stage. It adds decoupling between fetch and decode, credit-based request throttling, and branch redirect that flushes both the buffer and the in-flight memory read.

## Interface
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 0, PC loaded on reset.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  in  XLEN  new fetch target; bits [1:0] forced to 0.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  read address (current fetch PC).
- imem_rdata  in  XLEN  read data, valid the cycle after imem_req.
- inst_valid  out  1  FIFO head holds an instruction.
- inst_ready  in  1  decode accepts head.
- inst  out  XLEN  head instruction; 0 when inst_valid=0.
- inst_pc  out  XLEN  PC of head instruction; 0 when inst_valid=0.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State: fetch_pc, inflight flag, inflight_pc, FIFO storage (inst, pc pairs), rd_ptr/wr_ptr ($clog2(DEPTH) bits, wrap naturally), count.
- Request: imem_req = !redirect && (count + inflight) < DEPTH. imem_addr = fetch_pc. On request, fetch_pc += 4, inflight<=1, inflight_pc<=fetch_pc; otherwise inflight<=0.
- Response: if inflight=1 in a cycle, imem_rdata and inflight_pc are written to wr_ptr at that cycle's edge, wr_ptr++.
- Pop: inst_valid && inst_ready advances rd_ptr at the edge.
- Push and pop in the same cycle: count unchanged. The credit rule guarantees no push into a full FIFO.
- Redirect has priority over everything:
  - count<=0 and rd_ptr=wr_ptr<=0.
  - The response arriving in the redirect cycle is discarded and inflight<=0.
  - fetch_pc<={redirect_pc[XLEN-1:2],2'b00}. No request is issued in the redirect cycle.
  - A pop in the redirect cycle is still counted as accepted by decode but has no effect on the cleared state.
- PC arithmetic wraps modulo 2^XLEN.

## Timing
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, inflight=0, count=0, pointers 0.
  - imem_req forced 0 while rst=0; inst_valid=0, inst=0, inst_pc=0.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Latency:
  - Request in cycle k → data sampled and pushed at end of k+1 → inst_valid in k+2.
  - Throughput is one instruction per cycle with inst_ready held 1.
- Redirect in cycle N:
  - inst_valid=0 from N+1.
  - Request to target in N+1.
  - Target instruction presented in N+3.
- Backpressure: with inst_ready=0, requests stop once count+inflight=DEPTH. Resume the cycle after a pop frees a credit.
- Reset mid-operation: all state cleared immediately; pending response ignored.

## Configuration
- FETCH_STATS_EN defined: adds outputs fetched_cnt (32) and redirect_cnt (32), both reset to 0 and wrapping.
  - fetched_cnt increments on each accepted pop, excluding pops in a redirect cycle.
  - redirect_cnt increments on each redirect cycle.
- FETCH_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset release, imem[i]=0x1000+i, inst_ready=1 → inst_valid at cycle 2; inst/inst_pc sequence 0x1000/0, 0x1001/4, 0x1002/8 on consecutive cycles.
- inst_ready=0 from reset, DEPTH=4 → exactly 4 requests issued; count=4; imem_req=0 thereafter. One pop restores one request next cycle; count returns to 4.
- Redirect in steady stream, redirect_pc=0x43 → next cycle inst_valid=0, count=0; imem_addr=0x40; first inst_pc=0x40 three cycles after redirect; no PC from the old stream appears.
- Redirect coinciding with a pop and an arriving response → response dropped; count=0 next cycle.
- rst pulsed low for one cycle while count=3 → outputs 0 immediately; fetching restarts at RESET_PC.
- FETCH_STATS_EN: 10 pops and 2 redirects → fetched_cnt=10, redirect_cnt=2.
